// File: rtl/mod3_serial_lsb_checker.sv
// mod3_serial_lsb_checker
// Bit-serial divisibility-by-3 checker for WIDTH-bit words arriving LSB first
// over a valid/ready bit stream. Each finished word produces a registered
// remainder (0/1/2) and a divisible flag on a valid/ready result port.
//
// Optional feature macro: MOD3_SUFFIX_FLAGS_EN
//   When defined, the design adds a WIDTH-bit flags output where flags[i] = 1
//   iff word[i:0] mod 3 == 0, recorded as each bit is accepted.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_INIT    | reset state, left on the first edge after reset
// ST_COLLECT | accepting bits of the current word
// ST_RESULT  | holding a finished result until out_ready

module mod3_serial_lsb_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       rem,
  output logic             div3
`ifdef MOD3_SUFFIX_FLAGS_EN
  ,
  output logic [WIDTH-1:0] flags
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESULT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_run;
  logic             r_w;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_rem;
  logic             r_div3;
`ifdef MOD3_SUFFIX_FLAGS_EN
  logic [WIDTH-1:0] r_flags;
`endif

  logic             w_accept;
  logic             w_last;
  logic [1:0]       w_run_next;

  // Adds the current bit weight (1 when w=0, 2 when w=1) to a 0..2 remainder.
  // A lookup keeps everything in 2 bits so the remainder can never become 3.
  function automatic logic [1:0] mod3_add(input logic [1:0] r, input logic w);
    logic [1:0] res;
    res = 2'd0;
    case ({w, r})
      3'b0_00: res = 2'd1;
      3'b0_01: res = 2'd2;
      3'b0_10: res = 2'd0;
      3'b1_00: res = 2'd2;
      3'b1_01: res = 2'd0;
      3'b1_10: res = 2'd1;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // Next running remainder for the bit currently on bit_in.
  always_comb begin
    w_accept   = bit_valid && (r_state == ST_COLLECT);
    w_last     = (r_cnt == CNT_LAST);
    w_run_next = bit_in ? mod3_add(r_run, r_w) : r_run;
  end

  // Sequencing FSM with the accumulator and registered result fields.
  // clr outranks every other event, including a final bit or a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_run   <= 2'd0;
      r_w     <= 1'b0;
      r_cnt   <= '0;
      r_rem   <= 2'd0;
      r_div3  <= 1'b0;
`ifdef MOD3_SUFFIX_FLAGS_EN
      r_flags <= '0;
`endif
    end else if (clr) begin
      r_state <= ST_COLLECT;
      r_run   <= 2'd0;
      r_w     <= 1'b0;
      r_cnt   <= '0;
      r_rem   <= 2'd0;
      r_div3  <= 1'b0;
`ifdef MOD3_SUFFIX_FLAGS_EN
      r_flags <= '0;
`endif
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state <= ST_COLLECT;
          r_run   <= 2'd0;
          r_w     <= 1'b0;
          r_cnt   <= '0;
        end
        ST_COLLECT: begin
          if (w_accept) begin
            r_run <= w_run_next;
            r_w   <= ~r_w;
`ifdef MOD3_SUFFIX_FLAGS_EN
            r_flags[r_cnt] <= (w_run_next == 2'd0);
`endif
            if (w_last) begin
              // Final bit is folded straight into the published remainder.
              r_state <= ST_RESULT;
              r_rem   <= w_run_next;
              r_div3  <= (w_run_next == 2'd0);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            r_state <= ST_COLLECT;
            r_run   <= 2'd0;
            r_w     <= 1'b0;
            r_cnt   <= '0;
            r_rem   <= 2'd0;
            r_div3  <= 1'b0;
`ifdef MOD3_SUFFIX_FLAGS_EN
            r_flags <= '0;
`endif
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Handshake outputs decode state only; result fields come from registers.
  assign bit_ready = (r_state == ST_COLLECT);
  assign out_valid = (r_state == ST_RESULT);
  assign rem       = r_rem;
  assign div3      = r_div3;
`ifdef MOD3_SUFFIX_FLAGS_EN
  assign flags     = r_flags;
`endif

endmodule

// File: tb/tb_mod3_serial_lsb_checker.sv
// Self-checking bench for mod3_serial_lsb_checker (WIDTH=8 and WIDTH=3).
// Expected results are computed from whole-word arithmetic and queued when a
// word is driven; they are popped and compared when the DUT presents a result.

module tb_mod3_serial_lsb_checker;
  localparam int W = 8;

  typedef struct {
    logic [1:0]  rem;
    logic        div3;
    logic [63:0] flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic out_ready = 1'b0;
  logic bit_ready, out_valid, div3;
  logic [1:0] rem;
  logic bit_in3 = 1'b0;
  logic bit_valid3 = 1'b0;
  logic out_ready3 = 1'b0;
  logic bit_ready3, out_valid3, div3_3;
  logic [1:0] rem3;
`ifdef MOD3_SUFFIX_FLAGS_EN
  logic [W-1:0] flags;
  logic [2:0]   flags3;
`endif

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint last_hs = 0;
  exp_t   sb[$];

  mod3_serial_lsb_checker #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .out_valid(out_valid), .out_ready(out_ready),
    .rem(rem), .div3(div3)
`ifdef MOD3_SUFFIX_FLAGS_EN
    , .flags(flags)
`endif
  );

  mod3_serial_lsb_checker #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_in(bit_in3), .bit_valid(bit_valid3),
    .bit_ready(bit_ready3), .out_valid(out_valid3), .out_ready(out_ready3),
    .rem(rem3), .div3(div3_3)
`ifdef MOD3_SUFFIX_FLAGS_EN
    , .flags(flags3)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] word, input int width);
    exp_t e;
    logic [63:0] pre;
    e.rem   = 2'(word % 64'd3);
    e.div3  = (e.rem == 2'd0);
    e.flags = '0;
    for (int i = 0; i < width; i++) begin
      pre = word & ((64'd2 << i) - 64'd1);
      e.flags[i] = ((pre % 64'd3) == 64'd0);
    end
    return e;
  endfunction

  task automatic send_bit(input logic b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bit_valid = 1'b0;
        bit_in = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    bit_in = b;
    bit_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bit_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bit_ready) check("bit_ready_wait", 64'(bit_ready), 64'd1);
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] word, input bit gaps);
    sb.push_back(model(64'(word), W));
    for (int i = 0; i < W; i++) send_bit(word[i], gaps);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("latency_bit_ready", 64'(bit_ready), 64'd0);
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rem"}, 64'(rem), 64'(e.rem));
      check({tag, "_div3"}, 64'(div3), 64'(e.div3));
`ifdef MOD3_SUFFIX_FLAGS_EN
      check({tag, "_flags"}, 64'(flags), e.flags);
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_period_ge_9"}, 64'((cyc - last_hs) >= 64'(W + 1)), 64'd1);
    last_hs = cyc;
    check({tag, "_after_hs_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_after_hs_ready"}, 64'(bit_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] words[4];
    exp_t e3;
    logic [2:0] w3;
    int t;
    words[0] = 8'h07; words[1] = 8'h05; words[2] = 8'hFF; words[3] = 8'h00;

    // Reset values while rst_n is low, then bit_ready one edge after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bit_ready", 64'(bit_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rem", 64'(rem), 64'd0);
    check("rst_div3", 64'(div3), 64'd0);
`ifdef MOD3_SUFFIX_FLAGS_EN
    check("rst_flags", 64'(flags), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rel_bit_ready_pre_edge", 64'(bit_ready), 64'd0);
    @(posedge clk); #1;
    check("rel_bit_ready", 64'(bit_ready), 64'd1);
    last_hs = cyc;
    out_ready = 1'b1;

    // 0x09 with no gaps: remainder 0, flags 0xF8.
    send_word(8'h09, 1'b0);
    wait_result("w09");

    // Back-to-back words with random gaps.
    foreach (words[i]) begin
      send_word(words[i], 1'b1);
      wait_result($sformatf("seq%0d", i));
    end

    // Stalled result: held stable, no bits consumed while bit_valid is high.
    out_ready = 1'b0;
    send_word(8'h07, 1'b0);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_rem", 64'(rem), 64'd1);
      check("stall_bit_ready", 64'(bit_ready), 64'd0);
    end
    bit_valid = 1'b0;
    wait_result("stall07");
    send_word(8'h05, 1'b0);
    wait_result("post_stall05");

    // clr after 3 bits of 0xFF, then a clean 0x07.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_out_valid", 64'(out_valid), 64'd0);
    check("clr_bit_ready", 64'(bit_ready), 64'd1);
    check("clr_rem", 64'(rem), 64'd0);
    send_word(8'h07, 1'b0);
    wait_result("clr07");

    // clr on the same edge as the final bit wins over completion.
    for (int i = 0; i < W - 1; i++) send_bit(1'b1, 1'b0);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    bit_valid = 1'b0;
    check("clr_last_out_valid", 64'(out_valid), 64'd0);
    check("clr_last_bit_ready", 64'(bit_ready), 64'd1);
    send_word(8'h05, 1'b0);
    wait_result("clr_last05");

    // Asynchronous reset mid-word.
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_word_bit_ready", 64'(bit_ready), 64'd0);
    check("arst_word_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_word_rel_ready", 64'(bit_ready), 64'd1);

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    send_word(8'h07, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_res_out_valid", 64'(out_valid), 64'd0);
    check("arst_res_rem", 64'(rem), 64'd0);
    check("arst_res_div3", 64'(div3), 64'd0);
    check("arst_res_bit_ready", 64'(bit_ready), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_res_rel_ready", 64'(bit_ready), 64'd1);
    last_hs = cyc;
    out_ready = 1'b1;
    send_word(8'h0C, 1'b0);
    wait_result("post_rst0C");

    // WIDTH=3 instance, word 3'b110: prefixes 0, 2, 6 -> flags 3'b101.
    w3 = 3'b110;
    sb.push_back(model(64'(w3), 3));
    for (int i = 0; i < 3; i++) begin
      bit_in3 = w3[i];
      bit_valid3 = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bit_ready3 && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("w3_bit_ready", 64'(bit_ready3), 64'd1);
      @(posedge clk); #1;
      bit_valid3 = 1'b0;
    end
    check("w3_out_valid", 64'(out_valid3), 64'd1);
    check("w3_sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e3 = sb.pop_front();
      check("w3_rem", 64'(rem3), 64'(e3.rem));
      check("w3_div3", 64'(div3_3), 64'(e3.div3));
`ifdef MOD3_SUFFIX_FLAGS_EN
      check("w3_flags", 64'(flags3), e3.flags);
`endif
    end
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    check("w3_after_hs_ready", 64'(bit_ready3), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
